// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned INST_W = 32;

   localparam logic [XLEN-1:0] PC_RESET_DEF = 64'h0000_0000_8000_0000;

   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [XLEN-1:0]   addr;
   } fetch_pkt_t;

   localparam int unsigned PKT_W = $bits(fetch_pkt_t);

   // Fetch addresses are always word aligned.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/if_stage_inst_fifo.sv
// DEPTH-entry synchronous FIFO of {inst, inst_addr} with flush; head is read
// straight from storage so the outputs are register driven.
module inst_fifo
   import if_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [PKT_W-1:0] i_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic             o_valid,
   output logic [PKT_W-1:0] o_head,
   output logic [CW-1:0]    o_count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PKT_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_count;

   logic w_push;
   logic w_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_push = i_push & ~i_flush;
   assign w_pop  = i_pop & (r_count != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= next_ptr(r_wr);
         end
         if (w_pop) r_rd <= next_ptr(r_rd);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign o_valid = (r_count != '0);
   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response
// buffering and redirect flush with stale-response dropping.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [63:0] PC_RESET = PC_RESET_DEF,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [63:0] inst_addr
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned UW = CW + 1;

   logic [0:0]      r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_rsp_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop;

   logic [0:0]      w_state_nxt;
   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] w_rsp_pc_nxt;
   logic [CW-1:0]   w_outstanding_nxt;
   logic [CW-1:0]   w_drop_nxt;

   logic            w_pop;
   logic            w_accept;
   logic            w_keep;
   logic [UW-1:0]   w_used;
   logic [CW-1:0]   w_count;
   fetch_pkt_t      w_push_pkt;
   fetch_pkt_t      w_head;

   assign w_pop    = inst_valid & inst_ready;
   // Credits cover in-flight requests plus buffered entries; a same-cycle pop frees one.
   assign w_used   = UW'(r_outstanding) + UW'(w_count) - UW'(w_pop);
   assign imem_req_valid = (r_state == ST_RUN) & ~redirect_valid & (w_used < UW'(DEPTH));
   assign w_accept = imem_req_valid & imem_req_ready;
   assign w_keep   = imem_rsp_valid & (r_drop == '0) & ~redirect_valid;

   assign w_push_pkt.inst = imem_rsp_data;
   assign w_push_pkt.addr = r_rsp_pc;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= ST_BOOT;
         r_pc          <= align_pc(PC_RESET);
         r_rsp_pc      <= align_pc(PC_RESET);
         r_outstanding <= '0;
         r_drop        <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_rsp_pc      <= w_rsp_pc_nxt;
         r_outstanding <= w_outstanding_nxt;
         r_drop        <= w_drop_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_rsp_pc_nxt      = r_rsp_pc;
      w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);
      w_drop_nxt        = r_drop;

      if (r_state == ST_BOOT) w_state_nxt = ST_RUN;

      if (w_accept) w_pc_nxt = r_pc + XLEN'(4);
      if (w_keep)   w_rsp_pc_nxt = r_rsp_pc + XLEN'(4);
      if (imem_rsp_valid && (r_drop != '0)) w_drop_nxt = r_drop - CW'(1);

      // Everything still in flight after this cycle belongs to the old path.
      if (redirect_valid) begin
         w_pc_nxt     = align_pc(redirect_pc);
         w_rsp_pc_nxt = align_pc(redirect_pc);
         w_drop_nxt   = w_outstanding_nxt;
      end
   end

   inst_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_keep),
      .i_data  (w_push_pkt),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .o_valid (inst_valid),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign imem_req_addr = align_pc(r_pc);
   assign inst          = w_head.inst;
   assign inst_addr     = w_head.addr;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage: owns the PC, issues word-aligned fetch requests to instruction memory over a valid/ready request channel, and collects in-order responses into a small buffer. It presents `{inst, inst_addr}` pairs to the decode stage through a valid/ready handshake. On a taken branch or jump from execute it flushes the buffer and discards stale in-flight responses.

## Interface
Parameters:
- `PC_RESET`, 64'h0000_0000_8000_0000: PC loaded on reset.
- `DEPTH`, 2: instruction-buffer entries; also the cap on outstanding requests plus buffered entries.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  64  fetch address, always `[1:0]=0`.
- `imem_rsp_valid`  in  1  response valid, in request order, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  fetched instruction.
- `redirect_valid`  in  1  one-cycle pulse, taken branch/jump.
- `redirect_pc`  in  64  new PC; bits `[1:0]` ignored (forced 0).
- `inst_valid`  out  1  buffer head valid.
- `inst_ready`  in  1  decode accepts head.
- `inst`  out  32  head instruction.
- `inst_addr`  out  64  head PC.

## Operation
- State: `pc` (64), `outstanding` (0..DEPTH), `drop` (0..DEPTH), buffer `count` (0..DEPTH), FSM `BOOT`/`RUN`.
- FSM: reset → `BOOT`. `BOOT` → `RUN` on the next cycle with `rst`=1; no request is issued in `BOOT`. `RUN` is permanent until reset.
- `pop` = `inst_valid & inst_ready`. `accept` = `imem_req_valid & imem_req_ready`.
- `imem_req_valid` = `RUN & !redirect_valid & (outstanding + count − pop < DEPTH)`. This is a combinational path from `inst_ready` to the request. A request counts only on `accept`; withdrawal of valid is legal.
- On `accept`: `pc += 4`, `outstanding += 1`.
- On `imem_rsp_valid`: `outstanding −= 1`. If `drop > 0`, then `drop −= 1` and the data is discarded. Otherwise `{data, addr}` is pushed. The address comes from a per-response PC FIFO, or equivalently `pc − 4·(outstanding)` tracked as `rsp_pc`. The buffer cannot overflow because of the credit rule.
- On `redirect_valid`:
  - buffer cleared (`count` = 0);
  - `pc` = `{redirect_pc[63:2], 2'b0}`;
  - `drop` = `outstanding` after this cycle's response/accept updates;
  - no request this cycle;
  - a response arriving in the same cycle is discarded;
  - a `pop` in the same cycle still completes, but decode must ignore it.
- `imem_rsp_valid` while `outstanding == 0` is illegal; the bench asserts on it.
- PC arithmetic is modulo 2^64; wrap-around is silent.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=`PC_RESET`, `inst_valid`=0, `inst`=0, `inst_addr`=0. All counters are 0.
- First request: the second cycle after `rst` rises (one `BOOT` cycle).
- Latency: a response in cycle N produces `inst_valid` in cycle N+1 (registered buffer, no bypass).
- Throughput: with `imem_req_ready`=1, 1-cycle memory and `inst_ready`=1, one instruction per cycle in steady state.
- Buffer full and `inst_ready`=0: requests stop once `outstanding + count == DEPTH`. Head outputs are held stable while `inst_valid & !inst_ready`.
- Redirect: first request to the new PC is issued the cycle after the pulse. Stale responses are silently consumed.
- Reset mid-operation: all state returns to reset values. Responses arriving after reset are illegal; the memory model must also be reset.

## Structure
- `defines.v`: `` `PC_RESET ``, `` `INST_BUS `` (31:0); reuse `` `REG_BUS ``.
- One sub-module: `inst_fifo`, a DEPTH-entry synchronous FIFO of `{inst, inst_addr}` with push, pop, flush, count, and a head valid output. `if_stage` holds the PC, counters and FSM.

## Test plan
- Reset release, `imem_req_ready`=1, 1-cycle memory → first request to 0x8000_0000 one cycle after `BOOT`; `inst_valid` two cycles later with `inst_addr`=0x8000_0000.
- Streaming with `inst_ready`=1 → consecutive cycles deliver `inst_addr` 0x8000_0000, 0x8000_0004, 0x8000_0008 and so on, with no bubbles.
- `inst_ready`=0 for 10 cycles → at most 2 accepted requests; `inst`/`inst_addr` stable; release resumes in order with no loss or duplication.
- Memory latency 3, two requests outstanding, redirect to 0x8000_1002 → both stale responses dropped; next `inst_addr`=0x8000_1000.
- Redirect coincident with a response and with a pop → response discarded, buffer empty next cycle, new request issued the following cycle.
- `rst`=0 for one cycle mid-stream → all outputs return to reset values; fetch restarts at `PC_RESET`.
